// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ROB_SIZE_DEFAULT  = 16;
   localparam int unsigned ROB_IDX_W_DEFAULT = 4;
   localparam int unsigned REG_W             = 5;
   localparam int unsigned XLEN              = 32;

   // Payload held for each in-flight instruction (busy/ready live in flag vectors).
   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  value;
      logic             is_branch;
      logic             pred_taken;
      logic             taken;
      logic [XLEN-1:0]  target;
      logic [XLEN-1:0]  pc;
   } rob_entry_t;

   // Correct next PC after a branch resolves; pc + 4 wraps at 32 bits.
   function automatic logic [XLEN-1:0] redirect_pc(input logic taken,
                                                   input logic [XLEN-1:0] target,
                                                   input logic [XLEN-1:0] pc);
      return taken ? target : pc + 32'd4;
   endfunction

endpackage

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage: allocate at tail, CDB result write, retire clear, flush,
// one head read port and two operand read ports.
module reorder_buffer_entry_array
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned SIZE  = ROB_SIZE_DEFAULT,
   parameter int unsigned IDX_W = ROB_IDX_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_en,
   input  logic [IDX_W-1:0] alloc_idx,
   input  logic [4:0]       alloc_rd,
   input  logic             alloc_is_branch,
   input  logic             alloc_pred_taken,
   input  logic [31:0]      alloc_pc,
   input  logic             cdb_en,
   input  logic [IDX_W-1:0] cdb_idx,
   input  logic [31:0]      cdb_value,
   input  logic             cdb_taken,
   input  logic [31:0]      cdb_target,
   input  logic             retire_en,
   input  logic [IDX_W-1:0] head_idx,
   output logic             head_ready,
   output logic [4:0]       head_rd,
   output logic [31:0]      head_value,
   output logic             head_is_branch,
   output logic             head_pred_taken,
   output logic             head_taken,
   output logic [31:0]      head_target,
   output logic [31:0]      head_pc,
   input  logic [IDX_W-1:0] rd_idx1,
   input  logic [IDX_W-1:0] rd_idx2,
   output logic             rd_ready1,
   output logic [31:0]      rd_value1,
   output logic             rd_ready2,
   output logic [31:0]      rd_value2
);

   logic [SIZE-1:0] busy_q, busy_d;
   logic [SIZE-1:0] ready_q, ready_d;
   rob_entry_t      entries_q [SIZE];

   logic cdb_hit;
   assign cdb_hit = cdb_en && busy_q[cdb_idx];

   // Flag next-state; retire is applied after the CDB write so a retiring
   // entry never keeps a stale ready bit.
   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      if (flush) begin
         busy_d  = '0;
         ready_d = '0;
      end else begin
         if (cdb_hit) begin
            ready_d[cdb_idx] = 1'b1;
         end
         if (retire_en) begin
            busy_d[head_idx]  = 1'b0;
            ready_d[head_idx] = 1'b0;
         end
         if (alloc_en) begin
            busy_d[alloc_idx]  = 1'b1;
            ready_d[alloc_idx] = 1'b0;
         end
      end
   end

   // Flag registers; reset discards every entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q  <= '0;
         ready_q <= '0;
      end else begin
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   // Payload needs no reset: it is only observed while the busy/ready flags say so.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (alloc_en) begin
            entries_q[alloc_idx].rd         <= alloc_rd;
            entries_q[alloc_idx].is_branch  <= alloc_is_branch;
            entries_q[alloc_idx].pred_taken <= alloc_pred_taken;
            entries_q[alloc_idx].pc         <= alloc_pc;
         end
         if (cdb_hit) begin
            entries_q[cdb_idx].value  <= cdb_value;
            entries_q[cdb_idx].taken  <= cdb_taken;
            entries_q[cdb_idx].target <= cdb_target;
         end
      end
   end

   // Asynchronous read ports.
   always_comb begin
      head_ready      = ready_q[head_idx];
      head_rd         = entries_q[head_idx].rd;
      head_value      = entries_q[head_idx].value;
      head_is_branch  = entries_q[head_idx].is_branch;
      head_pred_taken = entries_q[head_idx].pred_taken;
      head_taken      = entries_q[head_idx].taken;
      head_target     = entries_q[head_idx].target;
      head_pc         = entries_q[head_idx].pc;
      rd_ready1       = ready_q[rd_idx1];
      rd_value1       = entries_q[rd_idx1].value;
      rd_ready2       = ready_q[rd_idx2];
      rd_value2       = entries_q[rd_idx2].value;
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags in program order, captures CDB
// results, retires one entry per cycle and flushes on branch mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned ROB_SIZE  = ROB_SIZE_DEFAULT,
   parameter int unsigned ROB_IDX_W = ROB_IDX_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 alloc_valid,
   input  logic [4:0]           alloc_rd,
   input  logic                 alloc_is_branch,
   input  logic                 alloc_pred_taken,
   input  logic [31:0]          alloc_pc,
   output logic                 alloc_ready,
   output logic [ROB_IDX_W-1:0] alloc_tag,
   input  logic                 cdb_valid,
   input  logic [ROB_IDX_W-1:0] cdb_tag,
   input  logic [31:0]          cdb_value,
   input  logic                 cdb_taken,
   input  logic [31:0]          cdb_target,
   input  logic [ROB_IDX_W-1:0] query_tag1,
   input  logic [ROB_IDX_W-1:0] query_tag2,
   output logic                 query_ready1,
   output logic [31:0]          query_value1,
   output logic                 query_ready2,
   output logic [31:0]          query_value2,
   output logic                 commit_valid,
   output logic [4:0]           commit_rd,
   output logic [31:0]          commit_value,
   output logic [ROB_IDX_W-1:0] commit_tag,
   output logic                 jump_wrong,
   output logic [31:0]          jump_target,
   output logic                 empty
);

   localparam logic [ROB_IDX_W:0] FullCount = (ROB_IDX_W + 1)'(ROB_SIZE);

   logic [ROB_IDX_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_IDX_W:0]   count_q, count_d;

   logic                 commit_valid_d, jump_wrong_d;
   logic [4:0]           commit_rd_d;
   logic [31:0]          commit_value_d, jump_target_d;
   logic [ROB_IDX_W-1:0] commit_tag_d;

   logic        head_ready, head_is_branch, head_pred_taken, head_taken;
   logic [4:0]  head_rd;
   logic [31:0] head_value, head_target, head_pc;
   logic        entry_ready1, entry_ready2;
   logic [31:0] entry_value1, entry_value2;

   logic do_alloc, do_cdb, do_commit, mispredict;

   // No bypass from a same-cycle commit: fullness comes from registered count only.
   assign alloc_ready = count_q < FullCount;
   assign alloc_tag   = tail_q;
   assign empty       = (count_q == '0);

   assign do_alloc   = rdy && alloc_valid && alloc_ready;
   assign do_cdb     = rdy && cdb_valid;
   assign do_commit  = rdy && !empty && head_ready;
   assign mispredict = do_commit && head_is_branch && (head_taken != head_pred_taken);

   reorder_buffer_entry_array #(
      .SIZE  (ROB_SIZE),
      .IDX_W (ROB_IDX_W)
   ) u_entries (
      .clk              (clk),
      .rst              (rst),
      .flush            (mispredict),
      .alloc_en         (do_alloc && !mispredict),
      .alloc_idx        (tail_q),
      .alloc_rd         (alloc_rd),
      .alloc_is_branch  (alloc_is_branch),
      .alloc_pred_taken (alloc_pred_taken),
      .alloc_pc         (alloc_pc),
      .cdb_en           (do_cdb),
      .cdb_idx          (cdb_tag),
      .cdb_value        (cdb_value),
      .cdb_taken        (cdb_taken),
      .cdb_target       (cdb_target),
      .retire_en        (do_commit),
      .head_idx         (head_q),
      .head_ready       (head_ready),
      .head_rd          (head_rd),
      .head_value       (head_value),
      .head_is_branch   (head_is_branch),
      .head_pred_taken  (head_pred_taken),
      .head_taken       (head_taken),
      .head_target      (head_target),
      .head_pc          (head_pc),
      .rd_idx1          (query_tag1),
      .rd_idx2          (query_tag2),
      .rd_ready1        (entry_ready1),
      .rd_value1        (entry_value1),
      .rd_ready2        (entry_ready2),
      .rd_value2        (entry_value2)
   );

   // Operand lookup with same-cycle CDB bypass.
   always_comb begin
      query_ready1 = entry_ready1 || (cdb_valid && (cdb_tag == query_tag1));
      query_value1 = (cdb_valid && (cdb_tag == query_tag1)) ? cdb_value : entry_value1;
      query_ready2 = entry_ready2 || (cdb_valid && (cdb_tag == query_tag2));
      query_value2 = (cdb_valid && (cdb_tag == query_tag2)) ? cdb_value : entry_value2;
   end

   // Pointer and occupancy next-state; a mispredict flush overrides everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (mispredict) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_alloc) begin
            tail_d = tail_q + ROB_IDX_W'(1);
         end
         if (do_commit) begin
            head_d = head_q + ROB_IDX_W'(1);
         end
         case ({do_alloc, do_commit})
            2'b10:   count_d = count_q + (ROB_IDX_W + 1)'(1);
            2'b01:   count_d = count_q - (ROB_IDX_W + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Retire outputs: pulses last one cycle, data holds between commits.
   always_comb begin
      commit_valid_d = do_commit;
      commit_rd_d    = commit_rd;
      commit_value_d = commit_value;
      commit_tag_d   = commit_tag;
      jump_wrong_d   = mispredict;
      jump_target_d  = jump_target;
      if (do_commit) begin
         commit_rd_d    = head_rd;
         commit_value_d = head_value;
         commit_tag_d   = head_q;
      end
      if (mispredict) begin
         jump_target_d = redirect_pc(head_taken, head_target, head_pc);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_value <= '0;
         commit_tag   <= '0;
         jump_wrong   <= 1'b0;
         jump_target  <= '0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         commit_valid <= commit_valid_d;
         commit_rd    <= commit_rd_d;
         commit_value <= commit_value_d;
         commit_tag   <= commit_tag_d;
         jump_wrong   <= jump_wrong_d;
         jump_target  <= jump_target_d;
      end
   end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer (ROB) for the Tomasulo RISC-V core.
- Allocates one tag per dispatched instruction, captures results from the CDB, and retires in program order.
- Drives the other end of the reservation station's update interface: commit broadcast (rd and value) that clears register renaming, and the jump_wrong flush.
- Sits between decoder/RS/LSB (producers) and the register file/fetch (consumers).

Parameters:
- ROB_SIZE, 16, number of entries (power of two).
- ROB_IDX_W, 4, tag width, log2(ROB_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when 0, all state holds
- alloc_valid  in  1  dispatch request
- alloc_rd  in  5  destination register (0 = none)
- alloc_is_branch  in  1  conditional branch
- alloc_pred_taken  in  1  fetch prediction
- alloc_pc  in  32  instruction PC
- alloc_ready  out  1  not full (count < ROB_SIZE)
- alloc_tag  out  ROB_IDX_W  tag given to the current request (= tail)
- cdb_valid  in  1  result broadcast
- cdb_tag  in  ROB_IDX_W  producing entry
- cdb_value  in  32  result value
- cdb_taken  in  1  actual branch outcome
- cdb_target  in  32  actual taken target
- query_tag1/query_tag2  in  ROB_IDX_W  operand lookup from RS
- query_ready1/query_ready2  out  1  value available
- query_value1/query_value2  out  32  value
- commit_valid  out  1  one-cycle retire pulse (the RS update)
- commit_rd  out  5  retired destination
- commit_value  out  32  retired value
- commit_tag  out  ROB_IDX_W  retired tag
- jump_wrong  out  1  one-cycle mispredict flush
- jump_target  out  32  correct next PC
- empty  out  1  count == 0

Behaviour:
- Reset (rst=0, async): head=tail=count=0; all entry ready bits 0. commit_valid=0, commit_rd=0, commit_value=0, commit_tag=0, jump_wrong=0, jump_target=0. empty=1, alloc_ready=1.
- State: head, tail (ROB_IDX_W bits, wrap modulo ROB_SIZE), and count (ROB_IDX_W+1 bits).
- Per-entry fields: busy, ready, rd, value, is_branch, pred_taken, taken, target, pc.
- alloc_ready and alloc_tag are combinational from registered state. There is no same-cycle bypass from commit: when full, allocation stays blocked even in a commit cycle.
- Allocate when rdy && alloc_valid && alloc_ready: write the entry at tail with ready=0; tail+1.
- CDB: when rdy && cdb_valid, set ready=1 and store value/taken/target at cdb_tag. A CDB write to a non-busy entry is ignored.
- Commit: evaluated at head when rdy && count>0 && entry ready (registered). CDB-to-commit latency is at least 1 cycle.
  - At most one commit per cycle.
  - Next cycle: commit_valid=1 with rd/value/tag; head+1.
  - Commit pulses for rd=0 too; consumers ignore rd=0.
- Mispredict (branch at head with taken != pred_taken):
  - Commit as above, plus jump_wrong=1 and jump_target = taken ? target : pc+4 (32-bit wrap).
  - In the same edge: head=tail=count=0 and all busy cleared. Any allocation or CDB write in that cycle is dropped.
- Correctly predicted branches commit with no jump_wrong.
- count is updated by +alloc −commit, with simultaneous alloc and commit netting 0; flush overrides.
- Query (combinational): ready = entry ready || (cdb_valid && cdb_tag == query_tag). When the bypass hits, value is cdb_value. Outputs for a non-busy tag are don't-care.
- rdy=0: no state changes. commit_valid and jump_wrong are forced to 0 the next edge, so no duplicate pulses.
- Reset asserted mid-operation discards all entries immediately.

Decomposition:
- Shared define.v macros: ROB_SIZE, ROBINDEX bit range, REGINDEX, REGLINE, ADDR.
- Single module. Optionally factor the entry storage as rob_entry_array (write-at-tail, CDB write, two async read ports plus head read).

Test Plan:
1. Reset; alloc rd=1,2,3 → tags 0,1,2. CDB tag1=0x22 → no commit. CDB tag0=0x11 → commits rd1/0x11 then rd2/0x22 on consecutive cycles. CDB tag2=0x33 → rd3 commits; empty=1.
2. 16 allocs → alloc_ready=0; 17th ignored, tail=0. Ready and commit tag0 → alloc_ready=1 the following cycle; next alloc_tag=0 (wrap).
3. Branch tag0 pc=0x100 pred_taken=0, plus 2 younger allocs. CDB tag0 taken=1 target=0x200 → commit pulse with jump_wrong=1, jump_target=0x200. Next cycle empty=1, alloc_tag=0, and a younger CDB is ignored.
4. Branch pred_taken=1, actual not taken, pc=0x1FC → jump_target=0x200. Second case with matching prediction → jump_wrong stays 0.
5. query_tag1=3 (busy, not ready) with same-cycle cdb tag3=0xABCD → query_ready1=1, query_value1=0xABCD. Without the CDB → query_ready1=0.
6. Head ready with rdy=0 for 3 cycles → no commit_valid; rdy=1 → exactly one pulse. Then drop rst mid-stream → outputs 0 and empty=1 asynchronously.
